// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences ALU, unified memory and register file
// through fetch/decode/execute/memory/writeback, stalling on the memory ready handshake.
module multicycle_control #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       branch_eq_o,
   output logic       branch_ne_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       mem_to_reg_o,
   output logic       reg_dst_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic       illegal_op_o,
   output logic       mem_timeout_o,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      EXEC_I   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(WAIT_LIMIT);

   state_t           state;
   logic [5:0]       opcode_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_ORI:  return 3'b001;
         OP_LUI:  return 3'b010;
         OP_ANDI: return 3'b011;
         default: return 3'b100;
      endcase
   endfunction

   assign waiting = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready_i;

   // State, latched opcode and memory-wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         // Timeout only clears the counter; the access keeps waiting
         if (wait_cnt == LIMIT_CNT)
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;

         case (state)
            FETCH:    if (mem_ready_i) state <= DECODE;
            DECODE: begin
               opcode_q <= opcode_i;
               case (opcode_i)
                  OP_RTYPE:                         state <= EXEC_R;
                  OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: state <= EXEC_I;
                  OP_LW, OP_SW:                     state <= MEM_ADDR;
                  OP_BEQ, OP_BNE:                   state <= BRANCH;
                  OP_J:                             state <= JUMP;
                  default:                          state <= FETCH;
               endcase
            end
            MEM_ADDR: state <= (opcode_q == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready_i) state <= MEM_WB;
            MEM_WR:   if (mem_ready_i) state <= FETCH;
            EXEC_R:   state <= R_WB;
            EXEC_I:   state <= I_WB;
            default:  state <= FETCH;
         endcase
      end
   end

   // Outputs decode from the current state; everything is forced low while reset is high
   always_comb begin
      pc_write_o    = 1'b0;
      branch_eq_o   = 1'b0;
      branch_ne_o   = 1'b0;
      i_or_d_o      = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      ir_write_o    = 1'b0;
      mem_to_reg_o  = 1'b0;
      reg_dst_o     = 1'b0;
      reg_write_o   = 1'b0;
      alu_src_a_o   = 1'b0;
      alu_src_b_o   = 2'b00;
      alu_op_o      = 3'b000;
      pc_src_o      = 2'b00;
      illegal_op_o  = 1'b0;
      mem_timeout_o = 1'b0;
      state_o       = 4'd0;
      if (!reset) begin
         state_o       = state;
         mem_timeout_o = (wait_cnt == LIMIT_CNT);
         case (state)
            FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = 2'b01;
               alu_op_o    = 3'b100;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            DECODE: begin
               alu_src_b_o = 2'b11;
               alu_op_o    = 3'b100;
               case (opcode_i)
                  OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_ANDI,
                  OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: illegal_op_o = 1'b0;
                  default:                            illegal_op_o = 1'b1;
               endcase
            end
            MEM_ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               alu_op_o    = 3'b100;
            end
            MEM_RD: begin
               i_or_d_o   = 1'b1;
               mem_read_o = 1'b1;
            end
            MEM_WB: begin
               mem_to_reg_o = 1'b1;
               reg_write_o  = 1'b1;
            end
            MEM_WR: begin
               i_or_d_o    = 1'b1;
               mem_write_o = 1'b1;
            end
            EXEC_R, R_WB: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = 3'b111;
               reg_dst_o   = (state == R_WB);
               reg_write_o = (state == R_WB);
            end
            EXEC_I, I_WB: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               alu_op_o    = imm_alu_op(opcode_q);
               reg_write_o = (state == I_WB);
            end
            BRANCH: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = 3'b101;
               pc_src_o    = 2'b01;
               branch_eq_o = (opcode_q == OP_BEQ);
               branch_ne_o = (opcode_q == OP_BNE);
            end
            JUMP: begin
               pc_write_o = 1'b1;
               pc_src_o   = 2'b10;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory stalls,
// illegal opcode, wait timeout (WAIT_LIMIT = 4) and mid-instruction reset.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic [19:0] ctrl;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
      .pc_write_o(pc_write), .branch_eq_o(branch_eq), .branch_ne_o(branch_ne),
      .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
      .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
      .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_op_o(alu_op), .pc_src_o(pc_src), .illegal_op_o(illegal_op),
      .mem_timeout_o(mem_timeout), .state_o(state)
   );

   assign ctrl = {pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                  illegal_op, mem_timeout};

   // Packs hand-chosen field values in the same order as ctrl
   function automatic logic [19:0] mk(input logic pcw, beq, bne, iord, mrd, mwr, irw, m2r,
                                      rdst, rw, srca, input logic [1:0] srcb,
                                      input logic [2:0] aop, input logic [1:0] pcs,
                                      input logic ill, tmo);
      return {pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill, tmo};
   endfunction

   task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                       input logic [3:0] exp_st, input logic [19:0] exp_ctrl);
      mem_ready = rdy;
      opcode    = op;
      #2;
      check({tag, " state"}, 20'(state), 20'(exp_st));
      check({tag, " ctrl"}, ctrl, exp_ctrl);
      @(posedge clk);
      #1;
   endtask

   logic [19:0] e_zero, e_fw, e_fw_tmo, e_fr, e_dec, e_dec_ill, e_exr, e_rwb;
   logic [19:0] e_exi_ori, e_iwb_ori, e_exi_lui, e_iwb_lui, e_ma, e_mrd, e_mwb, e_mwr;
   logic [19:0] e_beq, e_bne, e_jmp;

   initial begin
      //                 pcw beq bne iord mrd mwr irw m2r rdst rw srca srcb   aluop   pcsrc ill tmo
      e_zero    = 20'd0;
      e_fw      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00, 0, 0);
      e_fw_tmo  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00, 0, 1);
      e_fr      = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b100, 2'b00, 0, 0);
      e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b100, 2'b00, 0, 0);
      e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b100, 2'b00, 1, 0);
      e_exr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0, 0);
      e_rwb     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 3'b111, 2'b00, 0, 0);
      e_exi_ori = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 2'b00, 0, 0);
      e_iwb_ori = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 3'b001, 2'b00, 0, 0);
      e_exi_lui = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      e_iwb_lui = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 3'b010, 2'b00, 0, 0);
      e_ma      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00, 0, 0);
      e_mrd     = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_mwb     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_mwr     = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      e_beq     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b101, 2'b01, 0, 0);
      e_bne     = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b101, 2'b01, 0, 0);
      e_jmp     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0);

      reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
      for (int i = 0; i < 3; i++) step("reset", 1, 6'h00, 4'd0, e_zero);
      reset = 1'b0;

      // R-type; opcode_i changed after DECODE must be ignored
      step("r_fetch", 1, 6'h00, 4'd0, e_fr);
      step("r_dec",   1, 6'h00, 4'd1, e_dec);
      step("r_exec",  1, 6'h3F, 4'd6, e_exr);
      step("r_wb",    1, 6'h3F, 4'd7, e_rwb);

      step("ori_fetch", 1, 6'h00, 4'd0, e_fr);
      step("ori_dec",   1, 6'h0D, 4'd1, e_dec);
      step("ori_exec",  1, 6'h0F, 4'd8, e_exi_ori);
      step("ori_wb",    1, 6'h0F, 4'd9, e_iwb_ori);

      step("lui_fetch", 1, 6'h00, 4'd0, e_fr);
      step("lui_dec",   1, 6'h0F, 4'd1, e_dec);
      step("lui_exec",  1, 6'h0D, 4'd8, e_exi_lui);
      step("lui_wb",    1, 6'h0D, 4'd9, e_iwb_lui);

      // LW with three stall cycles; opcode_i flips to SW after DECODE
      step("lw_fetch", 1, 6'h00, 4'd0, e_fr);
      step("lw_dec",   1, 6'h23, 4'd1, e_dec);
      step("lw_addr",  1, 6'h2B, 4'd2, e_ma);
      for (int i = 0; i < 3; i++) step("lw_stall", 0, 6'h2B, 4'd3, e_mrd);
      step("lw_rd",    1, 6'h2B, 4'd3, e_mrd);
      step("lw_wb",    1, 6'h2B, 4'd4, e_mwb);

      step("sw_fetch", 1, 6'h00, 4'd0, e_fr);
      step("sw_dec",   1, 6'h2B, 4'd1, e_dec);
      step("sw_addr",  1, 6'h23, 4'd2, e_ma);
      for (int i = 0; i < 3; i++) step("sw_stall", 0, 6'h23, 4'd5, e_mwr);
      step("sw_wr",    1, 6'h23, 4'd5, e_mwr);

      step("beq_fetch", 1, 6'h00, 4'd0, e_fr);
      step("beq_dec",   1, 6'h04, 4'd1, e_dec);
      step("beq_br",    1, 6'h05, 4'd10, e_beq);
      step("bne_fetch", 1, 6'h00, 4'd0, e_fr);
      step("bne_dec",   1, 6'h05, 4'd1, e_dec);
      step("bne_br",    1, 6'h04, 4'd10, e_bne);
      step("j_fetch",   1, 6'h00, 4'd0, e_fr);
      step("j_dec",     1, 6'h02, 4'd1, e_dec);
      step("j_jump",    1, 6'h00, 4'd11, e_jmp);

      step("ill_fetch", 1, 6'h00, 4'd0, e_fr);
      step("ill_dec",   1, 6'h3F, 4'd1, e_dec_ill);

      // Timeout: four quiet wait cycles, pulse on the fifth, then counting restarts
      for (int i = 0; i < 4; i++) step("tmo_wait", 0, 6'h00, 4'd0, e_fw);
      step("tmo_pulse", 0, 6'h00, 4'd0, e_fw_tmo);
      step("tmo_after", 0, 6'h00, 4'd0, e_fw);
      step("tmo_ready", 1, 6'h00, 4'd0, e_fr);

      // Reset in MEM_WB suppresses the register write
      step("rst_dec",  1, 6'h23, 4'd1, e_dec);
      step("rst_addr", 1, 6'h23, 4'd2, e_ma);
      step("rst_rd",   1, 6'h23, 4'd3, e_mrd);
      reset = 1'b1;
      step("rst_in_wb", 1, 6'h23, 4'd0, e_zero);
      reset = 1'b0;
      step("rst_fetch", 1, 6'h00, 4'd0, e_fr);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
